// File: rtl/shift_seq_pkg.sv
// Shared types and constants for the iterative shift sequencer.
// The stage index walks FIRST_STAGE down to 0, one power-of-two shift per clock.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic SHIFT_SLL = 1'b0;
    localparam logic SHIFT_SRA = 1'b1;

    localparam int NUM_STAGES  = 5;
    localparam int FIRST_STAGE = NUM_STAGES - 1;
    localparam int IDX_W       = $clog2(NUM_STAGES);

    typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/shift_stage_mux.sv
// Single shared shift stage: shifts acc by 2^idx (sll zero fill / sra sign fill) when en is set.
// Purely combinational; every power is precomputed and idx picks one.
module shift_stage_mux
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc_i,
    input  idx_t             idx_i,
    input  logic             dir_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] acc_o
);

    logic [WIDTH-1:0] cand [NUM_STAGES];

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_pow
        localparam int P = 1 << k;
        assign cand[k] = (dir_i == SHIFT_SRA)
                       ? {{P{acc_i[WIDTH-1]}}, acc_i[WIDTH-1:P]}
                       : {acc_i[WIDTH-1-P:0], {P{1'b0}}};
    end

    always_comb begin
        acc_o = acc_i;
        if (en_i) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (idx_i == idx_t'(k)) begin
                    acc_o = cand[k];
                end
            end
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle 32-bit shifter: one request at a time, fixed 5-stage walk (16,8,4,2,1), done one cycle after the last stage.
// Starts are ignored unless IDLE; abort in SHIFT cancels with no done and leaves the old result in place.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [WIDTH-1:0]   data_operand_i,
    input  logic [SHAMT_W-1:0] ctrl_shiftamt_i,
    input  logic               ctrl_dir_i,
    output logic               ready_o,
    output logic               busy_o,
    output logic               done_o,
    output logic [WIDTH-1:0]   data_result_o
);

    state_t             state_q, state_d;
    idx_t               idx_q, idx_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    logic               dir_q, dir_d;

    logic               stage_en;
    logic [WIDTH-1:0]   stage_out;

    always_comb begin
        stage_en = 1'b0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (idx_q == idx_t'(k)) begin
                stage_en = shamt_q[k];
            end
        end
    end

    shift_stage_mux #(
        .WIDTH (WIDTH)
    ) u_stage (
        .acc_i (acc_q),
        .idx_i (idx_q),
        .dir_i (dir_q),
        .en_i  (stage_en),
        .acc_o (stage_out)
    );

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            idx_q    <= idx_t'(FIRST_STAGE);
            acc_q    <= '0;
            result_q <= '0;
            shamt_q  <= '0;
            dir_q    <= SHIFT_SLL;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            shamt_q  <= shamt_d;
            dir_q    <= dir_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        result_d = result_q;
        shamt_d  = shamt_q;
        dir_d    = dir_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i && !abort_i) begin
                    acc_d   = data_operand_i;
                    shamt_d = ctrl_shiftamt_i;
                    dir_d   = ctrl_dir_i;
                    idx_d   = idx_t'(FIRST_STAGE);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (abort_i) begin
                    idx_d   = idx_t'(FIRST_STAGE);
                    state_d = ST_IDLE;
                end else begin
                    acc_d = stage_out;
                    if (idx_q == '0) begin
                        result_d = stage_out;
                        idx_d    = idx_t'(FIRST_STAGE);
                        state_d  = ST_DONE;
                    end else begin
                        idx_d = idx_q - idx_t'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All outputs decode from registered state only, so no input reaches them combinationally.
    assign ready_o       = (state_q == ST_IDLE);
    assign busy_o        = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    assign done_o        = (state_q == ST_DONE);
    assign data_result_o = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: expected results are queued at issue and popped on done.
module tb_shift_sequencer;
    import shift_seq_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [31:0] data_operand;
    logic [4:0]  ctrl_shiftamt;
    logic        ctrl_dir;
    logic        ready;
    logic        busy;
    logic        done;
    logic [31:0] data_result;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q [$];

    shift_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clock_i         (clock),
        .reset_i         (reset),
        .start_i         (start),
        .abort_i         (abort),
        .data_operand_i  (data_operand),
        .ctrl_shiftamt_i (ctrl_shiftamt),
        .ctrl_dir_i      (ctrl_dir),
        .ready_o         (ready),
        .busy_o          (busy),
        .done_o          (done),
        .data_result_o   (data_result)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [31:0] op, input logic [4:0] sh, input logic dir);
        @(negedge clock);
        start         = 1'b1;
        data_operand  = op;
        ctrl_shiftamt = sh;
        ctrl_dir      = dir;
    endtask

    // Issues one op, optionally re-pulsing start in SHIFT (cycle 2) and DONE (cycle 6).
    task automatic run_op(input string tag, input logic [31:0] op, input logic [4:0] sh,
                          input logic dir, input logic [31:0] exp, input bit repulse);
        int          ndone;
        logic [31:0] e;
        exp_q.push_back(exp);
        issue(op, sh, dir);
        ndone = 0;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            @(negedge clock);
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    check({tag, "_latency"}, 32'(cyc), 32'd6);
                    if (exp_q.size() == 0) begin
                        check({tag, "_sb_empty"}, 32'd0, 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check({tag, "_result"}, data_result, e);
                    end
                end
            end
            if (cyc == 7) begin
                check({tag, "_ready_after"}, {31'd0, ready}, 32'd1);
            end
            start = 1'b0;
            if (repulse && (cyc == 2 || cyc == 6)) begin
                start         = 1'b1;
                data_operand  = 32'hDEAD_BEEF;
                ctrl_shiftamt = 5'd1;
                ctrl_dir      = ~dir;
            end
        end
        check({tag, "_ndone"}, 32'(ndone), 32'd1);
    endtask

    initial begin
        int ndone;
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        data_operand = '0; ctrl_shiftamt = '0; ctrl_dir = SHIFT_SLL;
        @(negedge clock);
        @(negedge clock);
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_busy",  {31'd0, busy},  32'd0);
        check("rst_done",  {31'd0, done},  32'd0);
        check("rst_result", data_result, 32'd0);
        reset = 1'b0;

        run_op("sll1_31", 32'h0000_0001, 5'd31, SHIFT_SLL, 32'h8000_0000, 1'b0);

        // Reset while idx=2: after E0 idx=4, after E1 idx=3, after E2 idx=2.
        issue(32'h1234_5678, 5'd7, SHIFT_SLL);
        @(negedge clock); start = 1'b0;
        check("shift_busy", {31'd0, busy}, 32'd1);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("midrst_ready", {31'd0, ready}, 32'd1);
        check("midrst_busy",  {31'd0, busy},  32'd0);
        check("midrst_done",  {31'd0, done},  32'd0);
        check("midrst_result", data_result, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (done) ndone++;
        end
        check("midrst_no_done", 32'(ndone), 32'd0);

        run_op("sra80_31", 32'h8000_0000, 5'd31, SHIFT_SRA, 32'hFFFF_FFFF, 1'b0);
        run_op("sllF_16",  32'hFFFF_FFFF, 5'd16, SHIFT_SLL, 32'hFFFF_0000, 1'b0);
        run_op("sra7F_16", 32'h7FFF_0000, 5'd16, SHIFT_SRA, 32'h0000_7FFF, 1'b0);
        run_op("sraF0_4",  32'hF000_0000, 5'd4,  SHIFT_SRA, 32'hFF00_0000, 1'b0);
        run_op("sh0",      32'h1234_5678, 5'd0,  SHIFT_SLL, 32'h1234_5678, 1'b0);
        run_op("sll_mix",  32'h0000_00F1, 5'd21, SHIFT_SLL, 32'h1E20_0000, 1'b0);
        run_op("sra_mix",  32'h8123_4567, 5'd11, SHIFT_SRA, 32'hFFF0_2468, 1'b0);
        run_op("repulse",  32'h00FF_0000, 5'd8,  SHIFT_SRA, 32'h0000_FF00, 1'b1);

        run_op("seed_aa",  32'hAAAA_5555, 5'd0,  SHIFT_SLL, 32'hAAAA_5555, 1'b0);
        // Abort while idx=1 (visible after E3); cancellation takes effect at E4.
        issue(32'h0000_0001, 5'd3, SHIFT_SLL);
        @(negedge clock); start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort_ready", {31'd0, ready}, 32'd1);
        check("abort_busy",  {31'd0, busy},  32'd0);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (done) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);
        check("abort_result", data_result, 32'hAAAA_5555);

        issue(32'h0000_0003, 5'd1, SHIFT_SLL);
        abort = 1'b1;
        @(negedge clock);
        start = 1'b0; abort = 1'b0;
        check("stab_ready", {31'd0, ready}, 32'd1);
        check("stab_busy",  {31'd0, busy},  32'd0);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (done) ndone++;
        end
        check("stab_no_done", 32'(ndone), 32'd0);
        check("stab_result", data_result, 32'hAAAA_5555);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
